// File: rtl/vid_pkg.sv
// Shared definitions for the video pattern source: pattern mode codes,
// FSM state codes and the colour-bar table.
package vid_pkg;

  typedef enum logic [2:0] {
    MODE_BARS    = 3'd0,
    MODE_RAMP    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_SOLID   = 3'd3,
    MODE_LINE    = 3'd4
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bar colour as a {R,G,B} on/off mask, left to right across the line.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;  // white
      3'd1:    return 3'b110;  // yellow
      3'd2:    return 3'b011;  // cyan
      3'd3:    return 3'b010;  // green
      3'd4:    return 3'b101;  // magenta
      3'd5:    return 3'b100;  // red
      3'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: run/idle FSM, h/v counters, registered blank/sync/marker
// flags, frame counter, and the look-ahead counter state used for pixels.
module video_timing_gen
  import vid_pkg::*;
#(
  parameter int COUNTER_WIDTH = 12,
  parameter int PPC           = 1,
  parameter int H_ACTIVE      = 1920,
  parameter int H_FP          = 88,
  parameter int H_SYNC        = 44,
  parameter int H_BP          = 148,
  parameter int V_ACTIVE      = 1080,
  parameter int V_FP          = 4,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 36,
  parameter int HSYNC_POL     = 1,
  parameter int VSYNC_POL     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [COUNTER_WIDTH-1:0] hcount,
  output logic [COUNTER_WIDTH-1:0] vcount,
  output logic [15:0]              frame_count,
  output logic                     hblank,
  output logic                     vblank,
  output logic                     active_video,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     sof,
  output logic                     eol,
  output logic [COUNTER_WIDTH-1:0] hcount_next,
  output logic [COUNTER_WIDTH-1:0] vcount_next,
  output logic                     active_next,
  output logic                     latch_strobe,
  output logic                     frame_end
);

  localparam int HT = (H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COUNTER_WIDTH-1:0] H_LAST = COUNTER_WIDTH'(HT - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_LAST = COUNTER_WIDTH'(VT - 1);
  localparam logic [COUNTER_WIDTH-1:0] H_ACT  = COUNTER_WIDTH'(H_ACTIVE / PPC);
  localparam logic [COUNTER_WIDTH-1:0] H_SS   = COUNTER_WIDTH'((H_ACTIVE + H_FP) / PPC);
  localparam logic [COUNTER_WIDTH-1:0] H_SE   = COUNTER_WIDTH'((H_ACTIVE + H_FP + H_SYNC) / PPC);
  localparam logic [COUNTER_WIDTH-1:0] V_ACT  = COUNTER_WIDTH'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] V_SS   = COUNTER_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNTER_WIDTH-1:0] V_SE   = COUNTER_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  state_e                     state_reg, state_next;
  logic [COUNTER_WIDTH-1:0]   hcount_reg, vcount_reg;
  logic [15:0]                frame_count_reg;
  logic hblank_reg, vblank_reg, active_reg, hsync_reg, vsync_reg, sof_reg, eol_reg;
  logic run_next;

  always_comb begin
    state_next   = state_reg;
    hcount_next  = hcount_reg;
    vcount_next  = vcount_reg;
    latch_strobe = 1'b0;
    frame_end    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        hcount_next = '0;
        vcount_next = '0;
        if (start) begin
          state_next   = ST_RUN;
          latch_strobe = 1'b1;
        end
      end
      ST_RUN: begin
        if (hcount_reg == H_LAST) begin
          hcount_next = '0;
          if (vcount_reg == V_LAST) begin
            // Only a completed frame may stop the raster.
            vcount_next = '0;
            frame_end   = 1'b1;
            if (start) latch_strobe = 1'b1;
            else       state_next   = ST_IDLE;
          end else begin
            vcount_next = vcount_reg + 1'b1;
          end
        end else begin
          hcount_next = hcount_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign run_next    = (state_next == ST_RUN);
  assign active_next = run_next && (hcount_next < H_ACT) && (vcount_next < V_ACT);

  // Flags are computed from the next counter state so they line up with hcount/vcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      frame_count_reg <= '0;
      hblank_reg      <= 1'b1;
      vblank_reg      <= 1'b1;
      active_reg      <= 1'b0;
      hsync_reg       <= ~HS_ON;
      vsync_reg       <= ~VS_ON;
      sof_reg         <= 1'b0;
      eol_reg         <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      if (frame_end) frame_count_reg <= frame_count_reg + 16'd1;
      hblank_reg <= !run_next || (hcount_next >= H_ACT);
      vblank_reg <= !run_next || (vcount_next >= V_ACT);
      active_reg <= active_next;
      hsync_reg  <= (run_next && hcount_next >= H_SS && hcount_next < H_SE) ? HS_ON : ~HS_ON;
      vsync_reg  <= (run_next && vcount_next >= V_SS && vcount_next < V_SE) ? VS_ON : ~VS_ON;
      sof_reg    <= run_next && (hcount_next == '0) && (vcount_next == '0);
      eol_reg    <= run_next && (hcount_next == H_ACT - 1'b1) && (vcount_next < V_ACT);
    end
  end

  assign hcount       = hcount_reg;
  assign vcount       = vcount_reg;
  assign frame_count  = frame_count_reg;
  assign hblank       = hblank_reg;
  assign vblank       = vblank_reg;
  assign active_video = active_reg;
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign sof          = sof_reg;
  assign eol          = eol_reg;

endmodule

// File: rtl/video_pattern_source.sv
// Multi-pattern video test source: frame-aligned mode/colour latch, moving
// line position and per-lane pattern generation into registered pixel data.
module video_pattern_source
  import vid_pkg::*;
#(
  parameter int COLOR_WIDTH   = 12,
  parameter int COUNTER_WIDTH = 12,
  parameter int PPC           = 1,
  parameter int H_ACTIVE      = 1920,
  parameter int H_FP          = 88,
  parameter int H_SYNC        = 44,
  parameter int H_BP          = 148,
  parameter int V_ACTIVE      = 1080,
  parameter int V_FP          = 4,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 36,
  parameter int HSYNC_POL     = 1,
  parameter int VSYNC_POL     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [2:0]                       mode,
  input  logic [3*COLOR_WIDTH-1:0]         solid_color,
  output logic [PPC*3*COLOR_WIDTH-1:0]     vid_data,
  output logic                             active_video,
  output logic                             hblank,
  output logic                             vblank,
  output logic                             hsync,
  output logic                             vsync,
  output logic [COUNTER_WIDTH-1:0]         hcount,
  output logic [COUNTER_WIDTH-1:0]         vcount,
  output logic [15:0]                      frame_count,
  output logic                             sof,
  output logic                             eol
);

  localparam int PW    = 3 * COLOR_WIDTH;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [15:0] LP_LAST = 16'(H_ACTIVE - 1);
  localparam logic [PW-1:0] WHITE = {PW{1'b1}};

  logic [COUNTER_WIDTH-1:0] hcount_next, vcount_next;
  logic active_next, latch_strobe, frame_end;
  logic [2:0]        mode_reg, mode_next;
  logic [PW-1:0]     solid_reg, solid_next;
  logic [15:0]       line_pos_reg, line_pos_next;
  logic [PPC*PW-1:0] pix_data, vid_data_reg;

  video_timing_gen #(
    .COUNTER_WIDTH(COUNTER_WIDTH), .PPC(PPC),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk(clk), .reset(reset), .start(start),
    .hcount(hcount), .vcount(vcount), .frame_count(frame_count),
    .hblank(hblank), .vblank(vblank), .active_video(active_video),
    .hsync(hsync), .vsync(vsync), .sof(sof), .eol(eol),
    .hcount_next(hcount_next), .vcount_next(vcount_next),
    .active_next(active_next), .latch_strobe(latch_strobe), .frame_end(frame_end)
  );

  // Pixels are built from the values the coming frame will use, so the first
  // cycle of a frame already reflects the freshly latched mode and line position.
  assign mode_next     = latch_strobe ? mode : mode_reg;
  assign solid_next    = latch_strobe ? solid_color : solid_reg;
  assign line_pos_next = frame_end ? ((line_pos_reg == LP_LAST) ? 16'd0 : line_pos_reg + 16'd1)
                                   : line_pos_reg;

  for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
    logic [31:0]   x;
    logic [2:0]    rgb;
    logic [PW-1:0] pix;

    assign x   = 32'(hcount_next) * 32'(PPC) + 32'(gi);
    assign rgb = bar_rgb(3'(x / BAR_W));

    always_comb begin
      pix = '0;
      case (mode_next)
        MODE_BARS:    pix = {{COLOR_WIDTH{rgb[2]}}, {COLOR_WIDTH{rgb[1]}}, {COLOR_WIDTH{rgb[0]}}};
        MODE_RAMP:    pix = {3{x[COLOR_WIDTH-1:0]}};
        MODE_CHECKER: pix = (x[5] ^ vcount_next[5]) ? WHITE : '0;
        MODE_SOLID:   pix = solid_next;
        MODE_LINE:    pix = (x == 32'(line_pos_next)) ? WHITE : '0;
        default:      pix = '0;
      endcase
    end

    assign pix_data[gi*PW +: PW] = pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg     <= '0;
      solid_reg    <= '0;
      line_pos_reg <= '0;
      vid_data_reg <= '0;
    end else begin
      mode_reg     <= mode_next;
      solid_reg    <= solid_next;
      line_pos_reg <= line_pos_next;
      vid_data_reg <= active_next ? pix_data : '0;
    end
  end

  assign vid_data = vid_data_reg;

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source on a small 24x12 raster:
// a reference model predicts every output each cycle via a scoreboard queue.
module tb_video_pattern_source;

  localparam logic [35:0] WHITE  = 36'hFFF_FFF_FFF;
  localparam logic [35:0] YELLOW = 36'hFFF_FFF_000;
  localparam logic [35:0] SOLID  = 36'h123_456_789;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [35:0] solid_color = SOLID;
  logic [35:0] vid_data;
  logic        active_video, hblank, vblank, hsync, vsync, sof, eol;
  logic [11:0] hcount, vcount;
  logic [15:0] frame_count;

  video_pattern_source #(
    .COLOR_WIDTH(12), .COUNTER_WIDTH(12), .PPC(1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .solid_color(solid_color),
    .vid_data(vid_data), .active_video(active_video), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .frame_count(frame_count), .sof(sof), .eol(eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hb, vb, av, hs, vs, sf, el;
    logic [11:0] hc, vc;
    logic [15:0] fc;
    logic [35:0] data;
  } exp_t;

  exp_t sb[$];
  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: what the DUT should be showing after the last edge.
  bit          m_run = 0;
  int          m_h = 0, m_v = 0, m_lpos = 0;
  logic [15:0] m_fc = '0;
  logic [2:0]  m_mode = '0;
  logic [35:0] m_solid = '0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (h=%0d v=%0d)", tag, obs, exp, m_h, m_v);
    end
  endtask

  function automatic logic [35:0] ref_pixel(input int x, input int y);
    logic [11:0] xr;
    xr = 12'(x);
    case (m_mode)
      3'd0: begin
        case (x / 2)
          0: return WHITE;
          1: return YELLOW;
          2: return 36'h000_FFF_FFF;
          3: return 36'h000_FFF_000;
          4: return 36'hFFF_000_FFF;
          5: return 36'hFFF_000_000;
          6: return 36'h000_000_FFF;
          default: return 36'h0;
        endcase
      end
      3'd1: return {xr, xr, xr};
      3'd2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? WHITE : 36'h0;
      3'd3: return m_solid;
      3'd4: return (x == m_lpos) ? WHITE : 36'h0;
      default: return 36'h0;
    endcase
  endfunction

  // One clock: advance the model from the driven inputs, queue its prediction,
  // clock the DUT, then compare what comes out against the queued entry.
  task automatic step();
    exp_t e;
    if (reset) begin
      m_run = 0; m_h = 0; m_v = 0; m_fc = '0; m_mode = '0; m_solid = '0; m_lpos = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_h = 0; m_v = 0; m_mode = mode; m_solid = solid_color;
      end
    end else if (m_h == 23) begin
      m_h = 0;
      if (m_v == 11) begin
        m_v = 0;
        m_fc = m_fc + 16'd1;
        m_lpos = (m_lpos == 15) ? 0 : m_lpos + 1;
        $display("frame %0d complete, mode %0d, start=%0b", m_fc, m_mode, start);
        if (start) begin
          m_mode = mode; m_solid = solid_color;
        end else begin
          m_run = 0;
        end
      end else begin
        m_v = m_v + 1;
      end
    end else begin
      m_h = m_h + 1;
    end
    e.hc   = 12'(m_h);
    e.vc   = 12'(m_v);
    e.fc   = m_fc;
    e.hb   = !m_run || (m_h >= 16);
    e.vb   = !m_run || (m_v >= 8);
    e.av   = !e.hb && !e.vb;
    e.hs   = m_run && (m_h >= 18) && (m_h < 20);
    e.vs   = m_run && (m_v >= 9) && (m_v < 11);
    e.sf   = m_run && (m_h == 0) && (m_v == 0);
    e.el   = m_run && (m_h == 15) && (m_v < 8);
    e.data = e.av ? ref_pixel(m_h, m_v) : 36'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_value("hcount", 64'(hcount), 64'(e.hc));
    check_value("vcount", 64'(vcount), 64'(e.vc));
    check_value("frame_count", 64'(frame_count), 64'(e.fc));
    check_value("hblank", 64'(hblank), 64'(e.hb));
    check_value("vblank", 64'(vblank), 64'(e.vb));
    check_value("active_video", 64'(active_video), 64'(e.av));
    check_value("hsync", 64'(hsync), 64'(e.hs));
    check_value("vsync", 64'(vsync), 64'(e.vs));
    check_value("sof", 64'(sof), 64'(e.sf));
    check_value("eol", 64'(eol), 64'(e.el));
    check_value("vid_data", 64'(vid_data), 64'(e.data));
  endtask

  task automatic run_until(input int h, input int v);
    for (int i = 0; i < 400; i++) begin
      if (m_run && m_h == h && m_v == v) break;
      step();
    end
    check_value("run_until_bound", 64'(m_h), 64'(h));
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (!m_run) break;
      step();
    end
    check_value("drain_bound", 64'(m_run), 64'd0);
  endtask

  initial begin
    // Reset, then idle with start low.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check_value("idle_hblank", 64'(hblank), 64'd1);
    check_value("idle_vblank", 64'(vblank), 64'd1);
    check_value("idle_hsync", 64'(hsync), 64'd0);
    check_value("idle_data", 64'(vid_data), 64'd0);

    // Colour bars, first frame.
    mode = 3'd0; start = 1'b1;
    step();
    check_value("first_sof", 64'(sof), 64'd1);
    check_value("first_hcount", 64'(hcount), 64'd0);
    check_value("first_white", 64'(vid_data), 64'(WHITE));
    step(); step();
    check_value("x2_yellow", 64'(vid_data), 64'(YELLOW));
    run_until(14, 0);
    check_value("x14_black", 64'(vid_data), 64'd0);
    run_until(15, 0);
    check_value("eol_x15", 64'(eol), 64'd1);
    run_until(18, 0);
    check_value("hsync_on", 64'(hsync), 64'd1);
    run_until(20, 0);
    check_value("hsync_off", 64'(hsync), 64'd0);

    // Checker next frame; mid-frame change to solid must wait a frame.
    mode = 3'd2;
    run_until(0, 0);
    check_value("frame_count_1", 64'(frame_count), 64'd1);
    run_until(0, 3);
    mode = 3'd3;
    step();
    check_value("checker_kept", 64'(vid_data), 64'd0);
    run_until(0, 0);
    check_value("solid_pixel", 64'(vid_data), 64'(SOLID));
    check_value("frame_count_2", 64'(frame_count), 64'd2);

    // Stop mid-frame: frame completes, then idle.
    run_until(0, 5);
    start = 1'b0;
    drain();
    check_value("stop_frame_count", 64'(frame_count), 64'd3);
    check_value("stop_hcount", 64'(hcount), 64'd0);
    for (int i = 0; i < 20; i++) step();

    // Moving line over 17 frames: positions 0..15 then back to 0.
    reset = 1'b1;
    step();
    reset = 1'b0; mode = 3'd4; start = 1'b1;
    for (int k = 0; k < 17; k++) begin
      run_until(k % 16, 0);
      check_value("line_pixel", 64'(vid_data), 64'(WHITE));
      run_until(0, 1);
    end
    start = 1'b0;
    drain();

    // Reset in the middle of a running frame, then restart.
    mode = 3'd1; start = 1'b1;
    run_until(7, 4);
    reset = 1'b1;
    step();
    check_value("rst_hcount", 64'(hcount), 64'd0);
    check_value("rst_hblank", 64'(hblank), 64'd1);
    check_value("rst_data", 64'(vid_data), 64'd0);
    reset = 1'b0;
    step();
    check_value("restart_sof", 64'(sof), 64'd1);
    for (int i = 0; i < 300; i++) step();
    start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
